// File: rtl/bcrypt_ctext_encrypt.sv
// Final bcrypt stage: loads P/S from BRAM, encrypts the 192-bit magic 64 times
// as 3 ECB Blowfish blocks, stores 6 ciphertext words and flags done.
module bcrypt_ctext_encrypt #(
    parameter logic [31:0] P_ARRAY    = 32'd4,
    parameter logic [31:0] P_S0       = 32'd76,
    parameter logic [31:0] CTEXT_ADDR = 32'd4264,
    parameter int unsigned N_PASSES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        BRAM_Clk_A,
    output logic        BRAM_Rst_A,
    output logic        BRAM_En_A,
    output logic [3:0]  BRAM_WE_A,
    output logic [31:0] BRAM_Addr_A,
    output logic [31:0] BRAM_WrData_A,
    input  logic [31:0] BRAM_RdData_A,
    output logic        busy,
    output logic [31:0] done
);

    localparam int unsigned N_P    = 18;
    localparam int unsigned N_CT   = 6;
    localparam int unsigned RAM_AW = 10;

    typedef enum logic [2:0] {
        IDLE, LOAD_P, LOAD_S, INIT_CT, ENC, NEXT, STORE, DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sub_q, sub_d;
    logic [RAM_AW-1:0]   idx_q, idx_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [1:0]          blk_q, blk_d;
    logic [6:0]          pass_q, pass_d;
    logic [2:0]          k_q, k_d;
    logic [31:0]         p_q [N_P];
    logic [31:0]         p_d [N_P];
    logic [31:0]         ct_q [N_CT];
    logic [31:0]         ct_d [N_CT];
    logic [31:0]         l_q, l_d, r_q, r_d, tmp_q, tmp_d;
    logic [3:0]          we_q, we_d;
    logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic [31:0]         ram [1 << RAM_AW];
    logic [31:0]         rd_a_q, rd_b_q;
    logic                ram_we_c;
    logic [RAM_AW-1:0]   ram_addr_a_c, ram_addr_b_c;
    logic [31:0]         x_c, f_c;
    logic [1:0]          blk_n_c;

    assign BRAM_Clk_A    = clk;
    assign BRAM_Rst_A    = 1'b0;
    assign BRAM_En_A     = 1'b1;
    assign BRAM_WE_A     = we_q;
    assign BRAM_Addr_A   = addr_q;
    assign BRAM_WrData_A = wdata_q;
    assign busy          = busy_q;
    assign done          = {24'h0, {8{done_q}}};

    // Local S-box copy: port A loads and reads, port B reads only
    always_ff @(posedge clk) begin
        if (ram_we_c) ram[ram_addr_a_c] <= BRAM_RdData_A;
        rd_a_q <= ram[ram_addr_a_c];
        rd_b_q <= ram[ram_addr_b_c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sub_q   <= '0;
            idx_q   <= '0;
            rnd_q   <= '0;
            blk_q   <= '0;
            pass_q  <= '0;
            k_q     <= '0;
            p_q     <= '{default: '0};
            ct_q    <= '{default: '0};
            l_q     <= '0;
            r_q     <= '0;
            tmp_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            pass_q  <= pass_d;
            k_q     <= k_d;
            p_q     <= p_d;
            ct_q    <= ct_d;
            l_q     <= l_d;
            r_q     <= r_d;
            tmp_q   <= tmp_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        idx_d        = idx_q;
        rnd_d        = rnd_q;
        blk_d        = blk_q;
        pass_d       = pass_q;
        k_d          = k_q;
        p_d          = p_q;
        ct_d         = ct_q;
        l_d          = l_q;
        r_d          = r_q;
        tmp_d        = tmp_q;
        we_d         = 4'h0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ram_we_c     = 1'b0;
        ram_addr_a_c = '0;
        ram_addr_b_c = '0;
        x_c          = l_q ^ p_q[5'(rnd_q)];
        f_c          = (tmp_q ^ rd_a_q) + rd_b_q;
        blk_n_c      = blk_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_P;
                    idx_d   = '0;
                    sub_d   = '0;
                    addr_d  = P_ARRAY;
                end
            end
            // Each word: address held two cycles, data captured on the third
            LOAD_P: begin
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd2) begin
                    sub_d             = '0;
                    p_d[idx_q[4:0]]   = BRAM_RdData_A;
                    if (idx_q == 10'(N_P - 1)) begin
                        idx_d   = '0;
                        addr_d  = P_S0;
                        state_d = LOAD_S;
                    end else begin
                        idx_d  = idx_q + 10'd1;
                        addr_d = P_ARRAY + (32'(idx_q + 10'd1) << 2);
                    end
                end
            end
            LOAD_S: begin
                sub_d        = sub_q + 2'd1;
                ram_addr_a_c = idx_q;
                if (sub_q == 2'd2) begin
                    sub_d    = '0;
                    ram_we_c = 1'b1;
                    if (idx_q == 10'd1023) begin
                        idx_d   = '0;
                        state_d = INIT_CT;
                    end else begin
                        idx_d  = idx_q + 10'd1;
                        addr_d = P_S0 + (32'(idx_q + 10'd1) << 2);
                    end
                end
            end
            INIT_CT: begin
                ct_d[0] = 32'h4f727068;
                ct_d[1] = 32'h65616e42;
                ct_d[2] = 32'h65686f6c;
                ct_d[3] = 32'h64657253;
                ct_d[4] = 32'h63727944;
                ct_d[5] = 32'h6f756274;
                l_d     = 32'h4f727068;
                r_d     = 32'h65616e42;
                pass_d  = '0;
                blk_d   = '0;
                rnd_d   = '0;
                sub_d   = '0;
                state_d = ENC;
            end
            // Round in 3 cycles: S0/S1 lookup, S2/S3 lookup, combine and swap
            ENC: begin
                case (sub_q)
                    2'd0: begin
                        l_d          = x_c;
                        ram_addr_a_c = {2'b00, x_c[31:24]};
                        ram_addr_b_c = {2'b01, x_c[23:16]};
                        sub_d        = 2'd1;
                    end
                    2'd1: begin
                        ram_addr_a_c = {2'b10, l_q[15:8]};
                        ram_addr_b_c = {2'b11, l_q[7:0]};
                        tmp_d        = rd_a_q + rd_b_q;
                        sub_d        = 2'd2;
                    end
                    default: begin
                        sub_d = '0;
                        if (rnd_q == 4'd15) begin
                            l_d     = l_q ^ p_q[17];
                            r_d     = r_q ^ f_c ^ p_q[16];
                            rnd_d   = '0;
                            state_d = NEXT;
                        end else begin
                            l_d   = r_q ^ f_c;
                            r_d   = l_q;
                            rnd_d = rnd_q + 4'd1;
                        end
                    end
                endcase
            end
            NEXT: begin
                ct_d[{blk_q, 1'b0}] = l_q;
                ct_d[{blk_q, 1'b1}] = r_q;
                if (blk_q != 2'd2) begin
                    blk_d   = blk_n_c;
                    l_d     = ct_q[{blk_n_c, 1'b0}];
                    r_d     = ct_q[{blk_n_c, 1'b1}];
                    state_d = ENC;
                end else if (pass_q < 7'(N_PASSES - 1)) begin
                    blk_d   = '0;
                    pass_d  = pass_q + 7'd1;
                    l_d     = ct_q[0];
                    r_d     = ct_q[1];
                    state_d = ENC;
                end else begin
                    k_d     = '0;
                    state_d = STORE;
                end
            end
            STORE: begin
                we_d    = 4'hF;
                addr_d  = CTEXT_ADDR + (32'(k_q) << 2);
                wdata_d = ct_q[k_q];
                k_d     = k_q + 3'd1;
                if (k_q == 3'(N_CT - 1)) state_d = DONE;
            end
            default: ;
        endcase

        // Host dropping start aborts and clears everything
        if (!start) begin
            state_d = IDLE;
            sub_d   = '0;
            idx_d   = '0;
            rnd_d   = '0;
            blk_d   = '0;
            pass_d  = '0;
            k_d     = '0;
            we_d    = 4'h0;
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_bcrypt_ctext_encrypt.sv
// Scoreboarded bench for bcrypt_ctext_encrypt: BRAM model, Blowfish reference
// model, write monitor, abort and reset-during-store scenarios.
module tb_bcrypt_ctext_encrypt;

    localparam logic [31:0] CT = 32'd4264;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        bclk, brst, ben;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata;
    logic        busy;
    logic [31:0] done;

    logic [31:0] bram [0:1199];
    logic [31:0] ct_mem [6];
    logic [31:0] exp_ct [6];
    logic [31:0] rd1;
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    bcrypt_ctext_encrypt dut (
        .clk(clk), .rst(rst), .start(start),
        .BRAM_Clk_A(bclk), .BRAM_Rst_A(brst), .BRAM_En_A(ben),
        .BRAM_WE_A(we), .BRAM_Addr_A(addr), .BRAM_WrData_A(wdata),
        .BRAM_RdData_A(rdata), .busy(busy), .done(done)
    );

    // BRAM: 2-cycle read latency; DUT writes land in the ctext shadow
    always @(posedge clk) begin
        int ci;
        rd1   <= (addr < 32'd4800) ? bram[addr[12:2]] : 32'h0;
        rdata <= rd1;
        ci = int'((addr - CT) >> 2);
        if (we == 4'hF && addr >= CT && addr < CT + 32'd24) ct_mem[ci] <= wdata;
    end

    // Write monitor: every BRAM write must match the next expected word
    always @(negedge clk) begin
        if (we != 4'h0) begin
            logic [63:0] e;
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write we=%h addr=%h data=%h", we, addr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (we !== 4'hF || {addr, wdata} !== e) begin
                    failures++;
                    $display("FAIL ctext_write got we=%h addr=%h data=%h want addr=%h data=%h",
                             we, addr, wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input bit ok, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] sbox(input int j, input logic [7:0] b);
        return bram[19 + 256 * j + int'(b)];
    endfunction

    function automatic logic [31:0] bf_f(input logic [31:0] x);
        return ((sbox(0, x[31:24]) + sbox(1, x[23:16])) ^ sbox(2, x[15:8])) + sbox(3, x[7:0]);
    endfunction

    // Reference: 64 passes of Blowfish ECB over the magic using P/S in bram
    task automatic push_expected();
        logic [31:0] c [6];
        logic [31:0] l, r, t;
        c = '{32'h4f727068, 32'h65616e42, 32'h65686f6c,
              32'h64657253, 32'h63727944, 32'h6f756274};
        for (int pass = 0; pass < 64; pass++) begin
            for (int b = 0; b < 3; b++) begin
                l = c[2 * b];
                r = c[2 * b + 1];
                for (int i = 0; i < 16; i++) begin
                    l = l ^ bram[1 + i];
                    r = r ^ bf_f(l);
                    t = l; l = r; r = t;
                end
                t = l; l = r; r = t;
                r = r ^ bram[17];
                l = l ^ bram[18];
                c[2 * b]     = l;
                c[2 * b + 1] = r;
            end
        end
        for (int k = 0; k < 6; k++) begin
            exp_ct[k] = c[k];
            exp_q.push_back({CT + 32'(4 * k), c[k]});
        end
    endtask

    task automatic fill_ps(input bit zero);
        for (int i = 1; i <= 1042; i++) bram[i] = zero ? 32'h0 : $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start, wait for done, then optionally hold start and check quiescence
    task automatic do_run(input bit hold);
        int cyc = 0;
        int busy_bad = 0;
        int n;
        logic [31:0] a;
        start = 1'b1;
        while (done !== 32'hFF && cyc < 16600) begin
            tick();
            cyc++;
            if (done !== 32'hFF && busy !== 1'b1) busy_bad++;
        end
        check("done_latency", done === 32'hFF && cyc <= 16500, 32'(cyc), 32'd16500);
        check("busy_during_run", busy_bad == 0, 32'(busy_bad), 32'd0);
        @(negedge clk);
        #1;
        check("all_words_written", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        if (hold) begin
            n = wr_cnt;
            a = addr;
            repeat (20) tick();
            check("hold_done", done === 32'hFF && busy === 1'b0 && wr_cnt == n && addr === a,
                  done, 32'hFF);
        end
        tick();
        start = 1'b0;
        tick();
        check("done_clear", done === 32'h0 && busy === 1'b0, done, 32'h0);
        repeat (3) tick();
    endtask

    initial begin
        int base;
        int guard;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 1200; i++) bram[i] = 32'h0;
        repeat (3) tick();
        check("reset_state", we === 4'h0 && done === 32'h0 && busy === 1'b0, done, 32'h0);
        rst = 1'b0;
        tick();

        // All-zero P/S leaves the magic untouched
        fill_ps(1'b1);
        push_expected();
        do_run(1'b1);

        // Abort mid-encryption, then a full rerun on random P/S
        fill_ps(1'b0);
        start = 1'b1;
        repeat (5000) tick();
        check("busy_mid_run", busy === 1'b1 && done === 32'h0, 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        check("abort_quiet", we === 4'h0 && done === 32'h0 && busy === 1'b0, 32'(we), 32'h0);
        repeat (5) tick();
        push_expected();
        do_run(1'b0);

        // Reset after three stored words, then a fresh run overwrites all six
        fill_ps(1'b0);
        push_expected();
        base  = wr_cnt;
        guard = 0;
        start = 1'b1;
        while (wr_cnt < base + 3 && guard < 17000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("store_reached", wr_cnt == base + 3, 32'(wr_cnt - base), 32'd3);
        rst = 1'b1;
        tick();
        check("rst_in_store", we === 4'h0 && done === 32'h0 && busy === 1'b0, 32'(we), 32'h0);
        start = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        fill_ps(1'b0);
        push_expected();
        do_run(1'b0);
        for (int k = 0; k < 6; k++) check("ctext_overwrite", ct_mem[k] === exp_ct[k], ct_mem[k], exp_ct[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
